// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the RV32I ALU.
// Selects and forwards operands, then holds them behind a valid/ready handshake.
// Ports: clk/rst; the in_* op from ID with in_valid/in_ready; flush.
// Ports: fwd_exmem_* and fwd_memwb_* bypass sources.
// Ports: out_valid/out_ready, operand_a/operand_b/alu_control to the ALU.
// Ports: out_rd_addr/out_reg_write/out_pc sideband.
// Macro ID_EX_FORWARD_EN enables EX/MEM and MEM/WB forwarding.
// Without it, the fwd_* ports are ignored.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [XLEN-1:0]       in_pc,
  input  logic                  in_a_sel_pc,
  input  logic                  in_b_sel_imm,
  input  logic [3:0]            in_alu_control,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_reg_write,
  input  logic                  flush,
  input  logic                  fwd_exmem_valid,
  input  logic [REG_ADDR_W-1:0] fwd_exmem_rd,
  input  logic [XLEN-1:0]       fwd_exmem_data,
  input  logic                  fwd_memwb_valid,
  input  logic [REG_ADDR_W-1:0] fwd_memwb_rd,
  input  logic [XLEN-1:0]       fwd_memwb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       operand_a,
  output logic [XLEN-1:0]       operand_b,
  output logic [3:0]            alu_control,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_reg_write,
  output logic [XLEN-1:0]       out_pc
);

  logic                  full;
  logic                  accept;
  logic                  rw_q;
  logic [XLEN-1:0]       rs1_val;
  logic [XLEN-1:0]       rs2_val;
  logic [XLEN-1:0]       a_next;
  logic [XLEN-1:0]       b_next;

  assign in_ready = !full || out_ready;
  assign accept   = in_valid && in_ready && !flush;

`ifdef ID_EX_FORWARD_EN
  logic ex1, ex2, mw1, mw2;

  // x0 never matches, so a hardwired zero is never overridden.
  assign ex1 = fwd_exmem_valid && (fwd_exmem_rd == in_rs1_addr)
            && (in_rs1_addr != '0);
  assign ex2 = fwd_exmem_valid && (fwd_exmem_rd == in_rs2_addr)
            && (in_rs2_addr != '0);
  assign mw1 = fwd_memwb_valid && (fwd_memwb_rd == in_rs1_addr)
            && (in_rs1_addr != '0);
  assign mw2 = fwd_memwb_valid && (fwd_memwb_rd == in_rs2_addr)
            && (in_rs2_addr != '0);

  // EX/MEM is the younger result, so it wins over MEM/WB.
  always_comb begin
    rs1_val = in_rs1_data;
    unique case (1'b1)
      ex1:     rs1_val = fwd_exmem_data;
      mw1:     rs1_val = fwd_memwb_data;
      default: rs1_val = in_rs1_data;
    endcase
  end

  always_comb begin
    rs2_val = in_rs2_data;
    unique case (1'b1)
      ex2:     rs2_val = fwd_exmem_data;
      mw2:     rs2_val = fwd_memwb_data;
      default: rs2_val = in_rs2_data;
    endcase
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{fwd_exmem_valid, fwd_exmem_rd,
                        fwd_exmem_data, fwd_memwb_valid,
                        fwd_memwb_rd, fwd_memwb_data,
                        in_rs1_addr, in_rs2_addr};
  assign rs1_val = in_rs1_data;
  assign rs2_val = in_rs2_data;
`endif

  assign a_next = in_a_sel_pc  ? in_pc  : rs1_val;
  assign b_next = in_b_sel_imm ? in_imm : rs2_val;

  // Payload changes only on accept, so it stays frozen while
  // stalled and keeps its last value once empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= 1'b0;
      operand_a   <= '0;
      operand_b   <= '0;
      alu_control <= '0;
      out_rd_addr <= '0;
      rw_q        <= 1'b0;
      out_pc      <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (accept) begin
      full        <= 1'b1;
      operand_a   <= a_next;
      operand_b   <= b_next;
      alu_control <= in_alu_control;
      out_rd_addr <= in_rd_addr;
      rw_q        <= in_reg_write;
      out_pc      <= in_pc;
    end else if (out_ready) begin
      full <= 1'b0;
    end
  end

  assign out_valid     = full;
  assign out_reg_write = rw_q && full;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage.
// Covers reset, issue, forwarding, mux select, stall, and flush.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr;
  logic [4:0]  in_rs2_addr;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic        in_a_sel_pc;
  logic        in_b_sel_imm;
  logic [3:0]  in_alu_control;
  logic [4:0]  in_rd_addr;
  logic        in_reg_write;
  logic        flush;
  logic        fwd_exmem_valid;
  logic [4:0]  fwd_exmem_rd;
  logic [31:0] fwd_exmem_data;
  logic        fwd_memwb_valid;
  logic [4:0]  fwd_memwb_rd;
  logic [31:0] fwd_memwb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_control;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc),
    .in_a_sel_pc(in_a_sel_pc), .in_b_sel_imm(in_b_sel_imm),
    .in_alu_control(in_alu_control),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .flush(flush),
    .fwd_exmem_valid(fwd_exmem_valid),
    .fwd_exmem_rd(fwd_exmem_rd),
    .fwd_exmem_data(fwd_exmem_data),
    .fwd_memwb_valid(fwd_memwb_valid),
    .fwd_memwb_rd(fwd_memwb_rd),
    .fwd_memwb_data(fwd_memwb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand_a(operand_a), .operand_b(operand_b),
    .alu_control(alu_control),
    .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write),
    .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid        = 1'b0;
    in_rs1_addr     = '0;
    in_rs2_addr     = '0;
    in_rs1_data     = '0;
    in_rs2_data     = '0;
    in_imm          = '0;
    in_pc           = '0;
    in_a_sel_pc     = 1'b0;
    in_b_sel_imm    = 1'b0;
    in_alu_control  = '0;
    in_rd_addr      = '0;
    in_reg_write    = 1'b0;
    flush           = 1'b0;
    fwd_exmem_valid = 1'b0;
    fwd_exmem_rd    = '0;
    fwd_exmem_data  = '0;
    fwd_memwb_valid = 1'b0;
    fwd_memwb_rd    = '0;
    fwd_memwb_data  = '0;
    out_ready       = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b exp 0", out_valid);
    end
    checks++;
    if (operand_a !== 32'h0 || operand_b !== 32'h0) begin
      errors++;
      $display("FAIL reset_ops got %h/%h exp 0/0", operand_a, operand_b);
    end
    checks++;
    if (alu_control !== 4'h0 || out_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got %h/%b exp 0/0", alu_control, out_reg_write);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_plain_issue();
    idle_inputs();
    in_valid     = 1'b1;
    in_rs1_data  = 32'd5;
    in_rs2_data  = 32'd7;
    in_rd_addr   = 5'd1;
    in_reg_write = 1'b1;
    in_pc        = 32'h40;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || operand_a !== 32'd5 || operand_b !== 32'd7) begin
      errors++;
      $display("FAIL plain got v=%b a=%h b=%h exp 1/5/7", out_valid, operand_a, operand_b);
    end
    checks++;
    if (out_reg_write !== 1'b1 || out_rd_addr !== 5'd1 || out_pc !== 32'h40) begin
      errors++;
      $display("FAIL plain_side got rw=%b rd=%0d pc=%h exp 1/1/40", out_reg_write, out_rd_addr, out_pc);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || operand_a !== 32'd5) begin
      errors++;
      $display("FAIL drain got v=%b rw=%b a=%h exp 0/0/5", out_valid, out_reg_write, operand_a);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      in_valid       = 1'b1;
      in_rs1_data    = 32'd10 + 32'(i);
      in_rs2_data    = 32'd20 + 32'(i);
      in_alu_control = 4'(i + 1);
      step();
      checks++;
      if (out_valid !== 1'b1 || operand_a !== 32'd10 + 32'(i)
          || operand_b !== 32'd20 + 32'(i) || alu_control !== 4'(i + 1)
          || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d got v=%b a=%h b=%h c=%h r=%b", i, out_valid, operand_a, operand_b, alu_control, in_ready);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_forward();
    logic [31:0] exp;
    idle_inputs();
    in_valid        = 1'b1;
    in_rs1_addr     = 5'd3;
    in_rs1_data     = 32'h1111;
    fwd_exmem_valid = 1'b1;
    fwd_exmem_rd    = 5'd3;
    fwd_exmem_data  = 32'hAAAA;
    fwd_memwb_valid = 1'b1;
    fwd_memwb_rd    = 5'd3;
    fwd_memwb_data  = 32'hBBBB;
    step();
`ifdef ID_EX_FORWARD_EN
    exp = 32'hAAAA;
`else
    exp = 32'h1111;
`endif
    checks++;
    if (operand_a !== exp) begin
      errors++;
      $display("FAIL fwd_prio got %h exp %h", operand_a, exp);
    end
    fwd_exmem_valid = 1'b0;
    step();
`ifdef ID_EX_FORWARD_EN
    exp = 32'hBBBB;
`else
    exp = 32'h1111;
`endif
    checks++;
    if (operand_a !== exp) begin
      errors++;
      $display("FAIL fwd_memwb got %h exp %h", operand_a, exp);
    end
    fwd_exmem_valid = 1'b1;
    in_rs1_addr     = 5'd0;
    fwd_exmem_rd    = 5'd0;
    fwd_memwb_rd    = 5'd0;
    in_rs1_data     = 32'h2222;
    step();
    checks++;
    if (operand_a !== 32'h2222) begin
      errors++;
      $display("FAIL fwd_x0 got %h exp 00002222", operand_a);
    end
    in_rs2_addr    = 5'd4;
    in_rs2_data    = 32'h3333;
    fwd_exmem_rd   = 5'd4;
    fwd_exmem_data = 32'hCCCC;
    step();
`ifdef ID_EX_FORWARD_EN
    exp = 32'hCCCC;
`else
    exp = 32'h3333;
`endif
    checks++;
    if (operand_b !== exp) begin
      errors++;
      $display("FAIL fwd_rs2 got %h exp %h", operand_b, exp);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_mux_select();
    idle_inputs();
    in_valid        = 1'b1;
    in_a_sel_pc     = 1'b1;
    in_pc           = 32'h100;
    in_rs1_data     = 32'h9;
    in_b_sel_imm    = 1'b1;
    in_imm          = 32'hFFFFFFFC;
    in_rs2_addr     = 5'd4;
    in_rs2_data     = 32'h8;
    fwd_exmem_valid = 1'b1;
    fwd_exmem_rd    = 5'd4;
    fwd_exmem_data  = 32'hDEAD;
    step();
    in_valid = 1'b0;
    checks++;
    if (operand_a !== 32'h100 || operand_b !== 32'hFFFFFFFC || out_pc !== 32'h100) begin
      errors++;
      $display("FAIL mux got a=%h b=%h pc=%h exp 100/fffffffc/100", operand_a, operand_b, out_pc);
    end
    step();
  endtask

  task automatic test_stall();
    idle_inputs();
    in_valid       = 1'b1;
    in_rs1_data    = 32'h55;
    in_rs2_data    = 32'h66;
    in_alu_control = 4'h5;
    step();
    out_ready      = 1'b0;
    in_rs1_data    = 32'h77;
    in_rs2_data    = 32'h88;
    in_alu_control = 4'h6;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || operand_a !== 32'h55
          || operand_b !== 32'h66 || alu_control !== 4'h5) begin
        errors++;
        $display("FAIL stall_%0d got v=%b r=%b a=%h b=%h c=%h", i, out_valid, in_ready, operand_a, operand_b, alu_control);
      end
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || operand_a !== 32'h77 || operand_b !== 32'h88
        || alu_control !== 4'h6) begin
      errors++;
      $display("FAIL stall_release got v=%b a=%h b=%h c=%h exp 1/77/88/6", out_valid, operand_a, operand_b, alu_control);
    end
    step();
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid    = 1'b1;
    in_rs1_data = 32'hC0;
    flush       = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept got %b exp 0", out_valid);
    end
    flush       = 1'b0;
    in_rs1_data = 32'hD0;
    step();
    in_valid    = 1'b1;
    in_rs1_data = 32'hE0;
    out_ready   = 1'b0;
    flush       = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || operand_a !== 32'hD0) begin
      errors++;
      $display("FAIL flush_stall got v=%b a=%h exp 0/d0", out_valid, operand_a);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    in_valid       = 1'b1;
    in_rs1_data    = 32'hF0;
    in_alu_control = 4'h3;
    step();
    out_ready = 1'b0;
    flush     = 1'b1;
    rst       = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || operand_a !== 32'h0 || alu_control !== 4'h0) begin
      errors++;
      $display("FAIL flush_rst got v=%b a=%h c=%h exp 0/0/0", out_valid, operand_a, alu_control);
    end
    rst   = 1'b0;
    flush = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || operand_a !== 32'hF0) begin
      errors++;
      $display("FAIL post_rst got v=%b a=%h exp 1/f0", out_valid, operand_a);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || operand_a !== 32'h0) begin
      errors++;
      $display("FAIL rst_stall got v=%b a=%h exp 0/0", out_valid, operand_a);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_plain_issue();
    test_back_to_back();
    test_forward();
    test_mux_select();
    test_stall();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
